// File: rtl/gcd_pkg.sv
// Shared constants for the subtract-based GCD controller and its datapath.
// State encoding, operand-mux select values and operand width.
package gcd_pkg;

  localparam int GCD_W = 4;

  localparam logic SEL_EXT = 1'b0;
  localparam logic SEL_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CMP  = 3'd2,
    SUBX = 3'd3,
    SUBY = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for the 4-bit subtract-based GCD datapath: drives operand muxes
// and load enables, consumes compare flags, flags zero operands and timeouts.
//
//   state | meaning
//   IDLE  | waiting for go
//   LOAD  | capture external operands into x and y, clear iter
//   CMP   | evaluate eq/lt/zero and choose the next step
//   SUBX  | x <= x - y, iter += 1
//   SUBY  | y <= y - x, iter += 1
//   DONE  | load result register from x, one-cycle done pulse
//   ERR   | zero operand or timeout; err held until the next go
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int ITER_W   = 4,
  parameter int MAX_ITER = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              eq,
  input  logic              lt,
  input  logic              zero,
  output logic              x_sel,
  output logic              y_sel,
  output logic              x_ld,
  output logic              y_ld,
  output logic              out_ld,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter
);

  // MAX_ITER must stay below 2**ITER_W so the counter can never wrap.
  localparam logic [ITER_W-1:0] MAX_ITER_V = ITER_W'(MAX_ITER);

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (go) state_nxt = LOAD;
      LOAD: state_nxt = CMP;
      CMP: begin
        if (zero)                    state_nxt = ERR;
        else if (eq)                 state_nxt = DONE;
        else if (iter == MAX_ITER_V) state_nxt = ERR;
        else if (lt)                 state_nxt = SUBY;
        else                         state_nxt = SUBX;
      end
      SUBX: state_nxt = CMP;
      SUBY: state_nxt = CMP;
      DONE: state_nxt = go ? LOAD : IDLE;
      ERR:  if (go) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_sel  = SEL_EXT;
    y_sel  = SEL_EXT;
    x_ld   = 1'b0;
    y_ld   = 1'b0;
    out_ld = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    unique case (state)
      IDLE: ;
      LOAD: begin
        x_ld = 1'b1;
        y_ld = 1'b1;
        busy = 1'b1;
      end
      CMP: busy = 1'b1;
      SUBX: begin
        x_sel = SEL_SUB;
        x_ld  = 1'b1;
        busy  = 1'b1;
      end
      SUBY: begin
        y_sel = SEL_SUB;
        y_ld  = 1'b1;
        busy  = 1'b1;
      end
      DONE: begin
        out_ld = 1'b1;
        done   = 1'b1;
      end
      ERR: err = 1'b1;
      default: ;
    endcase
  end

  // iter holds in IDLE/DONE/ERR so the last run's count stays observable.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter <= '0;
    end else begin
      unique case (state)
        LOAD:       iter <= '0;
        SUBX, SUBY: iter <= iter + 1'b1;
        default:    iter <= iter;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Directed bench for gcd_ctrl with a behavioural 4-bit datapath closing the loop.
// A second instance with MAX_ITER = 3 exercises the timeout path.
module tb_gcd_ctrl;

  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_LOAD = 8'b0011_0100;
  localparam logic [7:0] O_CMP  = 8'b0000_0100;
  localparam logic [7:0] O_SUBX = 8'b1010_0100;
  localparam logic [7:0] O_SUBY = 8'b0101_0100;
  localparam logic [7:0] O_DONE = 8'b0000_1010;
  localparam logic [7:0] O_ERR  = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  logic go2 = 1'b0;
  logic [3:0] a_in = 4'd0;
  logic [3:0] b_in = 4'd0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // instance 1, default MAX_ITER
  logic eq, lt, zero, x_sel, y_sel, x_ld, y_ld, out_ld, busy, done, err;
  logic [3:0] iter;
  logic [3:0] dx = 4'd0, dy = 4'd0, dout = 4'd0;
  logic [7:0] outs;

  gcd_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .eq(eq), .lt(lt), .zero(zero),
    .x_sel(x_sel), .y_sel(y_sel), .x_ld(x_ld), .y_ld(y_ld), .out_ld(out_ld),
    .busy(busy), .done(done), .err(err), .iter(iter)
  );

  assign eq   = (dx == dy);
  assign lt   = (dx < dy);
  assign zero = (dx == 4'd0) || (dy == 4'd0);
  assign outs = {x_sel, y_sel, x_ld, y_ld, out_ld, busy, done, err};

  always @(posedge clk) begin
    if (x_ld)   dx   <= x_sel ? (dx - dy) : a_in;
    if (y_ld)   dy   <= y_sel ? (dy - dx) : b_in;
    if (out_ld) dout <= dx;
  end

  // instance 2, MAX_ITER = 3
  logic eq2, lt2, zero2, x_sel2, y_sel2, x_ld2, y_ld2, out_ld2, busy2, done2, err2;
  logic [3:0] iter2;
  logic [3:0] dx2 = 4'd0, dy2 = 4'd0, dout2 = 4'd0;

  gcd_ctrl #(.ITER_W(4), .MAX_ITER(3)) dut2 (
    .clk(clk), .rst(rst), .go(go2), .eq(eq2), .lt(lt2), .zero(zero2),
    .x_sel(x_sel2), .y_sel(y_sel2), .x_ld(x_ld2), .y_ld(y_ld2), .out_ld(out_ld2),
    .busy(busy2), .done(done2), .err(err2), .iter(iter2)
  );

  assign eq2   = (dx2 == dy2);
  assign lt2   = (dx2 < dy2);
  assign zero2 = (dx2 == 4'd0) || (dy2 == 4'd0);

  always @(posedge clk) begin
    if (x_ld2)   dx2   <= x_sel2 ? (dx2 - dy2) : a_in;
    if (y_ld2)   dy2   <= y_sel2 ? (dy2 - dx2) : b_in;
    if (out_ld2) dout2 <= dx2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete run: go for one cycle, then wait (bounded) for done.
  task automatic run(input logic [3:0] a, input logic [3:0] b, input int k,
                     input logic [3:0] res, input string tag);
    int t;
    a_in = a;
    b_in = b;
    go = 1'b1;
    tick();
    go = 1'b0;
    t = 1;
    chk({tag, "_load"}, outs, O_LOAD);
    while (!done && t < 40) begin
      tick();
      t++;
    end
    chk({tag, "_latency"}, t, 3 + 2 * k);
    chk({tag, "_iter"}, iter, k);
    chk({tag, "_done_outs"}, outs, O_DONE);
    tick();
    chk({tag, "_result"}, dout, res);
    chk({tag, "_idle_after"}, outs, O_IDLE);
  endtask

  logic [7:0] trace6 [7];
  logic       seen_done2;

  initial begin
    trace6[0] = O_LOAD; trace6[1] = O_CMP;  trace6[2] = O_SUBX; trace6[3] = O_CMP;
    trace6[4] = O_SUBY; trace6[5] = O_CMP;  trace6[6] = O_DONE;

    // Scenario 1: reset
    rst = 1'b1;
    tick();
    tick();
    chk("rst_outs", outs, O_IDLE);
    chk("rst_iter", iter, 0);
    rst = 1'b0;
    tick();
    chk("idle_no_go", outs, O_IDLE);

    // mid-run reset while in SUBX with iter = 1
    a_in = 4'd15; b_in = 4'd1;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("midrun_subx", outs, O_SUBX);
    chk("midrun_iter", iter, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_outs", outs, O_IDLE);
    chk("midrun_rst_iter", iter, 0);
    tick();
    chk("midrun_rst_stay", outs, O_IDLE);

    // Scenario 2: equal operands
    run(4'd9, 4'd9, 0, 4'd9, "eq99");

    // Scenario 3: 6,4 with explicit trace; go pulses during CMP/SUB ignored
    a_in = 4'd6; b_in = 4'd4;
    go = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      go = (i >= 1 && i <= 4);
      chk($sformatf("trace64_c%0d", i + 1), outs, trace6[i]);
    end
    go = 1'b0;
    chk("trace64_iter", iter, 2);
    tick();
    chk("trace64_result", dout, 2);
    chk("trace64_idle", outs, O_IDLE);
    chk("trace64_iter_hold", iter, 2);

    // Scenario 4: worst case without timeout
    run(4'd15, 4'd1, 14, 4'd1, "worst151");

    // Scenario 4b: timeout with MAX_ITER = 3
    a_in = 4'd15; b_in = 4'd1;
    go2 = 1'b1;
    tick();
    go2 = 1'b0;
    seen_done2 = 1'b0;
    for (int i = 2; i <= 9; i++) begin
      tick();
      if (done2) seen_done2 = 1'b1;
    end
    chk("tmo_err", err2, 1'b1);
    chk("tmo_iter", iter2, 3);
    chk("tmo_busy", busy2, 1'b0);
    chk("tmo_no_done", seen_done2, 1'b0);

    // Scenario 5: zero operand
    a_in = 4'd0; b_in = 4'd5;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    chk("zero_cmp", outs, O_CMP);
    tick();
    chk("zero_err_n3", outs, O_ERR);
    for (int i = 0; i < 10; i++) tick();
    chk("zero_err_held", outs, O_ERR);
    run(4'd5, 4'd5, 0, 4'd5, "zero_restart");

    // 0,0: zero wins over eq
    a_in = 4'd0; b_in = 4'd0;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    chk("zz_err", outs, O_ERR);
    go = 1'b1;
    a_in = 4'd3; b_in = 4'd3;
    tick();
    go = 1'b0;
    chk("zz_restart_load", outs, O_LOAD);
    tick();
    tick();
    chk("zz_restart_done", outs, O_DONE);
    tick();

    // Scenario 6: back-to-back with go held high
    a_in = 4'd8; b_in = 4'd12;
    go = 1'b1;
    begin
      int t;
      tick();
      t = 1;
      while (!done && t < 40) begin
        tick();
        t++;
      end
      chk("b2b1_latency", t, 7);
      chk("b2b1_iter", iter, 2);
      a_in = 4'd7; b_in = 4'd7;
      tick();
      chk("b2b_direct_load", outs, O_LOAD);
      chk("b2b1_result", dout, 4);
      tick();
      tick();
      chk("b2b2_done", outs, O_DONE);
      go = 1'b0;
      tick();
      chk("b2b2_result", dout, 7);
      chk("b2b2_idle", outs, O_IDLE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_ctrl.md
Name: gcd_ctrl

Overview:
- Control FSM for the 4-bit subtract-based GCD datapath.
- It is the driving end of the datapath's 2:1 operand muxes: it produces the x/y select lines and register load enables, and consumes the datapath compare flags.
- It provides a go/done start/finish handshake to the top level, and detects errors (zero operand, iteration timeout).

Parameters:
- ITER_W, 4, width of the subtraction-iteration counter.
- MAX_ITER, 15, subtraction count at which a compare without equality flags a timeout error. Must be < 2**ITER_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start request; sampled only in IDLE, ERR or DONE.
- eq  in  1  datapath flag: x == y (combinational from registered x, y).
- lt  in  1  datapath flag: x < y.
- zero  in  1  datapath flag: x == 0 or y == 0.
- x_sel  out  1  x mux select: 0 = external operand, 1 = subtractor result (x - y).
- y_sel  out  1  y mux select: 0 = external operand, 1 = subtractor result (y - x).
- x_ld  out  1  x register load enable.
- y_ld  out  1  y register load enable.
- out_ld  out  1  result register load enable (loads x).
- busy  out  1  high from LOAD through the last CMP.
- done  out  1  one-cycle pulse: result valid.
- err  out  1  error flag, held until restart or reset.
- iter  out  ITER_W  subtractions performed in the current or last run.

Behaviour:
- Reset (rst = 1 at clock edge):
  - state = IDLE, iter = 0, err = 0.
  - All outputs 0 (x_sel = y_sel = 0).
  - rst takes priority over every other input, including mid-run.
- Outputs are Moore-decoded from the registered state; there are no combinational paths from inputs to outputs.
- States and outputs:
  - IDLE: all outputs 0.
  - LOAD: x_sel = 0, y_sel = 0, x_ld = 1, y_ld = 1, busy = 1; iter cleared to 0.
  - CMP: busy = 1; no loads. The eq/lt/zero flags are evaluated this cycle.
  - SUBX: x_sel = 1, x_ld = 1, busy = 1; iter += 1.
  - SUBY: y_sel = 1, y_ld = 1, busy = 1; iter += 1.
  - DONE: out_ld = 1, done = 1 for exactly one cycle.
  - ERR: err = 1; busy = 0.
- Transitions:
  - IDLE: go -> LOAD; otherwise stay.
  - LOAD -> CMP, unconditionally.
  - CMP: checks in strict priority order:
    - zero -> ERR.
    - eq -> DONE.
    - iter == MAX_ITER -> ERR.
    - lt -> SUBY.
    - otherwise (x > y) -> SUBX.
  - SUBX -> CMP; SUBY -> CMP.
  - DONE: go -> LOAD (back-to-back run); otherwise -> IDLE.
  - ERR: hold and keep err = 1 until go; then -> LOAD, with err cleared on entry to LOAD.
- go is ignored in LOAD, CMP, SUBX and SUBY; there is no abort except rst.
- Latency (go sampled high in IDLE at edge N):
  - LOAD occupies cycle N+1; first CMP is N+2.
  - Each subtraction adds 2 cycles (SUB + CMP).
  - done is high in cycle N+3+2k, where k = number of subtractions; iter = k when done is high.
- iter rules:
  - Saturation is impossible, because the MAX_ITER check precedes any increment and MAX_ITER < 2**ITER_W.
  - iter holds its value in IDLE, DONE and ERR for observation.
- Simultaneous eq and lt (datapath fault): eq wins, per the priority order.
- zero with eq (e.g. 0,0): ERR wins.

Decomposition:
- Shared package gcd_pkg:
  - State encoding constants: IDLE, LOAD, CMP, SUBX, SUBY, DONE, ERR (3-bit).
  - Select constants SEL_EXT = 0, SEL_SUB = 1.
  - Operand width constant GCD_W = 4.
- Flat module. The state register, next-state logic, output decode and iter counter are small enough that no sub-module is warranted.

Test Plan:
- Bench: drives a behavioural 4-bit datapath model from the control outputs and returns eq/lt/zero to the DUT.
- Scenario 1, reset: rst held 2 cycles, including one pulse mid-run in SUBX state -> next cycle state = IDLE, all outputs 0, iter = 0, err = 0.
- Scenario 2, equal operands: x = 9, y = 9, go at edge N -> x_ld = y_ld = 1 at N+1; done = 1 and out_ld = 1 at N+3; iter = 0; result 9.
- Scenario 3, normal run: x = 6, y = 4 -> sequence SUBX then SUBY (x_sel = 1 then y_sel = 1); done at N+7; iter = 2; result 2.
- Scenario 4, worst case and timeout: x = 15, y = 1 -> 14 SUBX steps, done at N+31, iter = 14, result 1. Repeat with MAX_ITER = 3 -> err = 1 after the 4th CMP, iter = 3, no done pulse.
- Scenario 5, zero operand: x = 0, y = 5 -> ERR entered from the first CMP (cycle N+3); err held through 10 idle cycles; go then re-enters LOAD and clears err.
- Scenario 6, back-to-back runs and ignored go: go held high continuously with operands (8,12) then (7,7) -> DONE goes directly to LOAD; results 4 then 7. go pulses injected during CMP/SUB states cause no state change.
